division: RTL and testbench

//  Multi-cycle integer divider for the MIPS datapath. It executes DIV and DIVU.
//  It pairs with the shift-add multiplier and drives the HI/LO register pair.
//  The quotient goes to LO and the remainder goes to HI.
//  The control FSM starts it with a one-cycle `work` pulse and stalls until `endSignal`.

---
 rtl/division.sv | 94 +++++++++
 tb/tb_division.sv | 135 +++++++++++++
 2 files changed

// File: rtl/division.sv
// Multi-cycle restoring divider for DIV/DIVU: quotient to lo, remainder to hi.
// One quotient bit per cycle; result lands 33 cycles after the accepted work pulse.
module division #(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             work,
  input  logic             isSigned,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             endSignal,
  output logic             divByZero,
  output logic [CW-1:0]    counter
);

  typedef enum logic [1:0] {IDLE, DIVIDE, FIX, ZERO} state_t;

  state_t           state;
  logic [WIDTH-1:0] q, rem, dvs;
  logic             sign_q, sign_r;

  logic [WIDTH-1:0] mag_l, mag_r;
  logic [WIDTH:0]   rem_sh, diff;
  logic             fits;

  always_comb begin
    mag_l  = (isSigned && lhs[WIDTH-1]) ? -lhs : lhs;
    mag_r  = (isSigned && rhs[WIDTH-1]) ? -rhs : rhs;
    rem_sh = {rem, q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
    // rem_sh < 2*dvs always, so the borrow bit alone decides rem_sh >= dvs
    fits   = ~diff[WIDTH];
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lo        <= '0;
      hi        <= '0;
      counter   <= '0;
      divByZero <= 1'b0;
      endSignal <= 1'b1;
      q         <= '0;
      rem       <= '0;
      dvs       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (work) begin
          endSignal <= 1'b0;
          counter   <= '0;
          rem       <= '0;
          if (rhs == '0) begin
            q     <= lhs;
            state <= ZERO;
          end else begin
            q      <= mag_l;
            dvs    <= mag_r;
            sign_q <= isSigned & (lhs[WIDTH-1] ^ rhs[WIDTH-1]);
            sign_r <= isSigned & lhs[WIDTH-1];
            state  <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem     <= fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          q       <= {q[WIDTH-2:0], fits};
          counter <= counter + 1'b1;
          if (counter == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          lo        <= sign_q ? -q : q;
          hi        <= sign_r ? -rem : rem;
          divByZero <= 1'b0;
          endSignal <= 1'b1;
          counter   <= '0;
          state     <= IDLE;
        end
        default: begin
          lo        <= '1;
          hi        <= q;
          divByZero <= 1'b1;
          endSignal <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_division.sv
// Randomized and directed checks of division against a plain-arithmetic model.
module tb_division;
  logic        Clk = 0, reset = 1, work = 0, isSigned = 0;
  logic [31:0] lhs = 0, rhs = 0, lo, hi;
  logic        endSignal, divByZero;
  logic [4:0]  counter;
  int          checks = 0, failures = 0;
  logic [31:0] exp_lo = 0, exp_hi = 0;
  logic        exp_dz = 0;

  division dut (.Clk(Clk), .reset(reset), .work(work), .isSigned(isSigned),
                .lhs(lhs), .rhs(rhs), .lo(lo), .hi(hi), .endSignal(endSignal),
                .divByZero(divByZero), .counter(counter));

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // model: 64-bit arithmetic avoids the -2^31/-1 overflow; truncation toward zero
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] ql, output logic [31:0] rh, output logic dz);
    longint sa, sb;
    if (b == 0) begin
      ql = 32'hFFFFFFFF; rh = a; dz = 1;
    end else begin
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
      ql = 32'(sa / sb);
      rh = 32'(sa % sb);
      dz = 0;
    end
  endtask

  // mode 1: extra work pulses while busy (counter==5 and on the FIX edge)
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int mode);
    int k;
    logic [31:0] old_lo, old_hi;
    logic [31:0] nlo, nhi;
    logic ndz;
    model(a, b, s, nlo, nhi, ndz);
    old_lo = exp_lo; old_hi = exp_hi;
    lhs = a; rhs = b; isSigned = s; work = 1;
    @(posedge Clk); #1;
    work = 0;
    lhs = $urandom; rhs = $urandom; isSigned = $urandom_range(0, 1);
    chk("busy_after_e0", {31'b0, endSignal}, 32'd0);
    k = 0;
    while (!endSignal && k < 100) begin
      if (k == 5) begin
        chk("counter_mid", {27'b0, counter}, 32'd5);
        chk("lo_hold", lo, old_lo);
        chk("hi_hold", hi, old_hi);
      end
      if (mode == 1 && (k == 5 || k == 32)) begin
        work = 1; lhs = 8; rhs = 2; isSigned = 0;
      end else work = 0;
      @(posedge Clk); #1;
      k++;
    end
    work = 0;
    exp_lo = nlo; exp_hi = nhi; exp_dz = ndz;
    chk("latency", k, (b == 0) ? 32'd1 : 32'd33);
    chk("lo", lo, exp_lo);
    chk("hi", hi, exp_hi);
    chk("dz", {31'b0, divByZero}, {31'b0, exp_dz});
    chk("counter_end", {27'b0, counter}, 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_lo", lo, 0);
    chk("rst_hi", hi, 0);
    chk("rst_end", {31'b0, endSignal}, 1);
    chk("rst_dz", {31'b0, divByZero}, 0);
    chk("rst_cnt", {27'b0, counter}, 0);
    @(negedge Clk); reset = 0;
    @(negedge Clk);

    run_op(100, 7, 0, 0);
    run_op(32'hFFFFFFF9, 2, 1, 0);
    run_op(7, 32'hFFFFFFFE, 1, 0);
    run_op(32'hFFFFFFFF, 1, 0, 0);
    run_op(32'h80000000, 32'hFFFFFFFF, 1, 0);
    chk("min_by_m1_lo", lo, 32'h80000000);
    run_op(1234, 0, 0, 0);
    chk("dz_lo_const", lo, 32'hFFFFFFFF);
    run_op(9, 3, 0, 0);

    // reset mid-operation
    lhs = 1000; rhs = 3; isSigned = 0; work = 1;
    @(posedge Clk); #1; work = 0;
    for (int i = 0; i < 60 && counter != 10; i++) begin @(posedge Clk); #1; end
    chk("cnt_before_rst", {27'b0, counter}, 10);
    reset = 1; #1;
    chk("midrst_end", {31'b0, endSignal}, 1);
    chk("midrst_lo", lo, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_cnt", {27'b0, counter}, 0);
    @(negedge Clk); reset = 0; exp_lo = 0; exp_hi = 0;
    @(negedge Clk);
    run_op(50, 5, 0, 0);

    // work while busy and at the FIX edge is ignored
    run_op(1000, 3, 0, 1);
    chk("intf_lo", lo, 333);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      chk("no_restart", {31'b0, endSignal}, 1);
    end
    chk("intf_hold", lo, 333);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 0;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      run_op(a, b, 1'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 2)) @(posedge Clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
